// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared defaults, FSM states and redirect-cause enum for pc_gen.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int          PC_ADDR_W    = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam int          PC_INC       = 4;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_EXC  = 3'd1,
        RC_ERET = 3'd2,
        RC_BR   = 3'd3,
        RC_PEND = 3'd4,
        RC_SEQ  = 3'd5
    } redirect_cause_e;

endpackage

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Fetch program-counter generator with stall, buffered branch
//               redirect, exception vectoring and exception return.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_gen
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = PC_ADDR_W,
    parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
    parameter int          INC       = PC_INC,
    parameter logic [31:0] EXC_VEC   = PC_EXC_VEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              eret,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] epc,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] c_RESET_VEC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_EXC_VEC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_INC       = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] c_LOW_MASK  = ADDR_W'(INC - 1);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              misalign_q, misalign_d;

    redirect_cause_e   w_cause;
    logic [ADDR_W-1:0] w_br_aligned;

    assign w_br_aligned = br_target & ~c_LOW_MASK;

    // Priority arbitration among redirect sources; BR covers both the
    // immediate and the buffered (stalled) case.
    always_comb begin
        w_cause = RC_NONE;
        if (state_q == ST_RUN) begin
            if (exc_valid)                   w_cause = RC_EXC;
            else if (eret)                   w_cause = RC_ERET;
            else if (br_valid)               w_cause = RC_BR;
            else if (pend_valid_q && !stall) w_cause = RC_PEND;
            else if (!stall)                 w_cause = RC_SEQ;
        end
    end

    always_comb begin
        state_d       = ST_RUN;
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = 1'b0;
        case (w_cause)
            RC_EXC: begin
                pc_d         = c_EXC_VEC;
                epc_d        = exc_pc;
                pend_valid_d = 1'b0;
            end
            RC_ERET: begin
                pc_d         = epc_q;
                pend_valid_d = 1'b0;
            end
            RC_BR: begin
                misalign_d = |(br_target & c_LOW_MASK);
                if (stall) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = w_br_aligned;
                end else begin
                    pc_d         = w_br_aligned;
                    pend_valid_d = 1'b0;
                end
            end
            RC_PEND: begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
            end
            RC_SEQ: begin
                pc_d = pc_q + c_INC;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= c_RESET_VEC;
            epc_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
        end
    end

    assign ce       = (state_q == ST_RUN);
    assign pc       = pc_q;
    assign epc      = epc_q;
    assign misalign = misalign_q;

endmodule

`default_nettype wire
